// File: rtl/cdc_fifo_gray_dst_ext.sv
// Destination half of a gray-pointer CDC FIFO: synchronises the remote write pointer,
// serves entries on a valid/ready port, reports fill level and supports a synchronous flush.
module cdc_fifo_gray_dst_ext #(
   parameter int DataWidth  = 32,
   parameter int LogDepth   = 2,
   parameter int SyncStages = 2,
   parameter int OutputReg  = 0
) (
   input  logic                                  dst_clk_i,
   input  logic                                  dst_rst_ni,
   input  logic [2**LogDepth-1:0][DataWidth-1:0] async_data_i,
   input  logic [LogDepth:0]                     async_wptr_i,
   output logic [LogDepth:0]                     async_rptr_o,
   output logic [DataWidth-1:0]                  dst_data_o,
   output logic                                  dst_valid_o,
   input  logic                                  dst_ready_i,
   output logic [LogDepth:0]                     dst_fill_o,
   output logic                                  dst_empty_o,
   input  logic                                  dst_flush_i
);

   localparam int PtrW = LogDepth + 1;
   typedef logic [PtrW-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PtrW-1] = g[PtrW-1];
      for (int i = PtrW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   ptr_t                 r_wptr_sync [SyncStages];
   ptr_t                 r_rptr_b;
   ptr_t                 r_rptr_g;
   ptr_t                 w_wptr_g;
   ptr_t                 w_wptr_b;
   ptr_t                 w_fifo_cnt;
   ptr_t                 w_rptr_next;
   logic                 w_fifo_empty;
   logic                 w_pop;
   logic [DataWidth-1:0] w_head;

   // Write-pointer synchroniser: stage 0 is the only flop fed from the source domain
   always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
      if (!dst_rst_ni) begin
         for (int i = 0; i < SyncStages; i++) begin
            r_wptr_sync[i] <= '0;
         end
      end else begin
         r_wptr_sync[0] <= async_wptr_i;
         for (int i = 1; i < SyncStages; i++) begin
            r_wptr_sync[i] <= r_wptr_sync[i-1];
         end
      end
   end

   assign w_wptr_g     = r_wptr_sync[SyncStages-1];
   assign w_wptr_b     = gray2bin(w_wptr_g);
   assign w_fifo_empty = (w_wptr_g == bin2gray(r_rptr_b));
   assign w_fifo_cnt   = w_wptr_b - r_rptr_b;
   assign w_head       = async_data_i[r_rptr_b[LogDepth-1:0]];

   // Flush jumps to the synchronised write pointer and overrides any pop
   assign w_rptr_next = dst_flush_i ? w_wptr_b : (r_rptr_b + ptr_t'(w_pop));

   always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
      if (!dst_rst_ni) begin
         r_rptr_b <= '0;
         r_rptr_g <= '0;
      end else begin
         r_rptr_b <= w_rptr_next;
         r_rptr_g <= bin2gray(w_rptr_next);
      end
   end

   assign async_rptr_o = r_rptr_g;
   assign dst_empty_o  = (dst_fill_o == '0);

   generate
      if (OutputReg != 0) begin : g_oreg
         logic [DataWidth-1:0] r_oreg;
         logic                 r_ovalid;

         assign w_pop = !w_fifo_empty && (!r_ovalid || dst_ready_i) && !dst_flush_i;

         // Spill slot: refills in the same cycle it is consumed for full throughput
         always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
            if (!dst_rst_ni) begin
               r_oreg   <= '0;
               r_ovalid <= 1'b0;
            end else if (dst_flush_i) begin
               r_ovalid <= 1'b0;
            end else if (w_pop) begin
               r_oreg   <= w_head;
               r_ovalid <= 1'b1;
            end else if (dst_ready_i) begin
               r_ovalid <= 1'b0;
            end
         end

         assign dst_valid_o = r_ovalid;
         assign dst_data_o  = r_oreg;
         assign dst_fill_o  = w_fifo_cnt + ptr_t'(r_ovalid);
      end else begin : g_noreg
         assign dst_valid_o = !w_fifo_empty && !dst_flush_i;
         assign w_pop       = dst_valid_o && dst_ready_i;
         assign dst_data_o  = w_head;
         assign dst_fill_o  = w_fifo_cnt;
      end
   endgenerate

endmodule

// File: tb/tb_cdc_fifo_gray_dst_ext.sv
// Bench for cdc_fifo_gray_dst_ext: the bench plays the source half and drives two DUTs
// (no output register / 2 sync stages, and output register / 3 sync stages) from one stimulus.
module tb_cdc_fifo_gray_dst_ext;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [3:0][7:0] mem;
   logic [2:0]      wptr;
   logic            ready;
   logic            flush;
   logic [2:0]      rptr0, rptr1, fill0, fill1;
   logic [7:0]      data0, data1;
   logic            valid0, valid1, empty0, empty1;

   always #5 clk = ~clk;

   cdc_fifo_gray_dst_ext #(.DataWidth(8), .LogDepth(2), .SyncStages(2), .OutputReg(0)) u_dut0 (
      .dst_clk_i(clk), .dst_rst_ni(rst_n), .async_data_i(mem), .async_wptr_i(wptr),
      .async_rptr_o(rptr0), .dst_data_o(data0), .dst_valid_o(valid0), .dst_ready_i(ready),
      .dst_fill_o(fill0), .dst_empty_o(empty0), .dst_flush_i(flush));

   cdc_fifo_gray_dst_ext #(.DataWidth(8), .LogDepth(2), .SyncStages(3), .OutputReg(1)) u_dut1 (
      .dst_clk_i(clk), .dst_rst_ni(rst_n), .async_data_i(mem), .async_wptr_i(wptr),
      .async_rptr_o(rptr1), .dst_data_o(data1), .dst_valid_o(valid1), .dst_ready_i(ready),
      .dst_fill_o(fill1), .dst_empty_o(empty1), .dst_flush_i(flush));

   int n_chk = 0;
   int n_err = 0;

   // Reference model: absolute entry counts, independent of pointer encodings
   int wbin;
   int wdata [0:4095];
   int taken [2];
   int slot_v [2];
   int slot_d [2];
   int wsync [2];
   int hist [2][4];
   int sstg [2] = '{2, 3};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] g3(input int b);
      logic [2:0] x;
      x = 3'(b % 8);
      return x ^ (x >> 1);
   endfunction

   task automatic src_write(input logic [7:0] v);
      mem[wbin % 4] = v;
      wdata[wbin]   = int'(v);
      wbin++;
      wptr = g3(wbin);
   endtask

   task automatic check_model();
      int vis0, vis1;
      vis0 = wsync[0] - taken[0];
      vis1 = wsync[1] - taken[1];
      chk("m0_valid", 32'(valid0), 32'(vis0 > 0 && !flush));
      chk("m0_fill", 32'(fill0), 32'(vis0));
      chk("m0_empty", 32'(empty0), 32'(vis0 == 0));
      chk("m0_rptr", 32'(rptr0), 32'(g3(taken[0])));
      if (vis0 > 0 && !flush) chk("m0_data", 32'(data0), 32'(wdata[taken[0]]));
      chk("m1_valid", 32'(valid1), 32'(slot_v[1]));
      chk("m1_data", 32'(data1), 32'(slot_d[1]));
      chk("m1_fill", 32'(fill1), 32'(vis1 + slot_v[1]));
      chk("m1_empty", 32'(empty1), 32'(vis1 + slot_v[1] == 0));
      chk("m1_rptr", 32'(rptr1), 32'(g3(taken[1])));
   endtask

   task automatic cyc();
      #1;
      check_model();
      if (flush) taken[0] = wsync[0];
      else if (wsync[0] - taken[0] > 0 && ready) taken[0]++;
      if (flush) begin
         taken[1]  = wsync[1];
         slot_v[1] = 0;
      end else if (wsync[1] - taken[1] > 0 && (slot_v[1] == 0 || ready)) begin
         slot_d[1] = wdata[taken[1]];
         slot_v[1] = 1;
         taken[1]++;
      end else if (ready) begin
         slot_v[1] = 0;
      end
      for (int d = 0; d < 2; d++) begin
         for (int i = 3; i > 0; i--) hist[d][i] = hist[d][i-1];
         hist[d][0] = wbin;
         wsync[d]   = hist[d][sstg[d]-1];
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ready = 1'b0;
      flush = 1'b0;
      wbin  = 0;
      wptr  = '0;
      for (int d = 0; d < 2; d++) begin
         taken[d]  = 0;
         slot_v[d] = 0;
         slot_d[d] = 0;
         wsync[d]  = 0;
         for (int i = 0; i < 4; i++) hist[d][i] = 0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [2:0] prev0, prev1;
      logic       prev_fl;
      int         wraps;

      for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
      do_reset();

      // Reset / idle
      #1;
      chk("rst_rptr0", 32'(rptr0), 0);
      chk("rst_valid0", 32'(valid0), 0);
      chk("rst_fill0", 32'(fill0), 0);
      chk("rst_empty0", 32'(empty0), 1);
      chk("rst_data0", 32'(data0), 32'h A0);
      chk("rst_data1", 32'(data1), 0);
      chk("rst_valid1", 32'(valid1), 0);
      chk("rst_rptr1", 32'(rptr1), 0);
      repeat (3) cyc();

      // Write-to-valid latency
      src_write(8'hA0);
      #1 chk("lat_e0_valid0", 32'(valid0), 0);
      cyc();
      #1 chk("lat_e1_valid0", 32'(valid0), 0);
      cyc();
      #1;
      chk("lat_e2_valid0", 32'(valid0), 1);
      chk("lat_e2_data0", 32'(data0), 32'h A0);
      chk("lat_e2_fill1", 32'(fill1), 0);
      cyc();
      #1;
      chk("lat_e3_fill1", 32'(fill1), 1);
      chk("lat_e3_valid1", 32'(valid1), 0);
      cyc();
      #1;
      chk("lat_e4_valid1", 32'(valid1), 1);
      chk("lat_e4_data1", 32'(data1), 32'h A0);
      ready = 1'b1;
      cyc();
      #1;
      chk("pop_rptr0", 32'(rptr0), 32'b001);
      chk("pop_valid0", 32'(valid0), 0);
      chk("pop_rptr1", 32'(rptr1), 32'b001);
      ready = 1'b0;
      cyc();

      // Fill and backpressure
      do_reset();
      for (int i = 0; i < 4; i++) src_write(8'hA0 + 8'(i));
      repeat (4) cyc();
      #1;
      chk("bp_fill0", 32'(fill0), 4);
      chk("bp_data0", 32'(data0), 32'h A0);
      chk("bp_fill1", 32'(fill1), 4);
      chk("bp_valid1", 32'(valid1), 1);
      ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("drain_data0", 32'(data0), 32'h A0 + 32'(k));
         chk("drain_fill0", 32'(fill0), 32'(4 - k));
         chk("drain_data1", 32'(data1), 32'h A0 + 32'(k));
         chk("drain_fill1", 32'(fill1), 32'(4 - k));
         cyc();
      end
      #1;
      chk("drained_fill0", 32'(fill0), 0);
      chk("drained_rptr0", 32'(rptr0), 32'b110);
      chk("drained_fill1", 32'(fill1), 0);
      chk("drained_rptr1", 32'(rptr1), 32'b110);
      ready = 1'b0;
      cyc();

      // Randomised traffic with wrap, backpressure and occasional flush
      prev0   = rptr0;
      prev1   = rptr1;
      prev_fl = 1'b0;
      wraps   = 0;
      for (int n = 0; n < 400; n++) begin
         ready = ($urandom_range(3, 0) != 0);
         flush = ($urandom_range(24, 0) == 0);
         if ($urandom_range(1, 0) == 1 && wbin - taken[0] < 4 && wbin - taken[1] < 4)
            src_write(8'($urandom));
         #1;
         if (!prev_fl && rptr0 != prev0) chk("gray_step0", 32'($countones(rptr0 ^ prev0)), 1);
         if (!prev_fl && rptr1 != prev1) chk("gray_step1", 32'($countones(rptr1 ^ prev1)), 1);
         if (prev0 == 3'b100 && rptr0 == 3'b000) wraps++;
         prev0   = rptr0;
         prev1   = rptr1;
         prev_fl = flush;
         cyc();
      end
      chk("wrap_seen0", 32'(wraps > 0), 1);
      flush = 1'b0;

      // Flush with an unsynchronised write in flight
      do_reset();
      src_write(8'hB0);
      src_write(8'hB1);
      src_write(8'hB2);
      repeat (4) cyc();
      ready = 1'b1;
      flush = 1'b1;
      src_write(8'h5C);
      #1 chk("fl_valid0", 32'(valid0), 0);
      cyc();
      flush = 1'b0;
      ready = 1'b0;
      #1;
      chk("fl_fill0", 32'(fill0), 0);
      chk("fl_rptr0", 32'(rptr0), 32'b010);
      chk("fl_valid1", 32'(valid1), 0);
      chk("fl_fill1", 32'(fill1), 0);
      chk("fl_rptr1", 32'(rptr1), 32'b010);
      cyc();
      #1;
      chk("fl_late_valid0", 32'(valid0), 1);
      chk("fl_late_data0", 32'(data0), 32'h 5C);
      cyc();
      #1 chk("fl_late_fill1", 32'(fill1), 1);
      cyc();
      #1;
      chk("fl_late_valid1", 32'(valid1), 1);
      chk("fl_late_data1", 32'(data1), 32'h 5C);
      ready = 1'b1;
      repeat (4) cyc();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
